// File: rtl/dw_pkg.sv
// Shared depthwise/pointwise constants and the round-and-saturate helper.
package dw_pkg;

  localparam int KSIZE_DEF = 3;
  localparam int NTAPS_DEF = KSIZE_DEF * KSIZE_DEF;
  localparam int SAT_W     = 128;

  function automatic int acc_width(input int dw);
    return 2 * dw + 8;
  endfunction

  // Round half up at bit frac, then clamp to the signed dw-bit range.
  function automatic logic signed [63:0] sat_round(input logic signed [SAT_W-1:0] acc,
                                                   input int frac, input int dw);
    logic signed [SAT_W-1:0] one, q, hi, lo;
    one = 1;
    q   = acc;
    if (frac > 0) q = (acc + (one <<< (frac - 1))) >>> frac;
    hi = (one <<< (dw - 1)) - one;
    lo = -(one <<< (dw - 1));
    if (q > hi) q = hi;
    else if (q < lo) q = lo;
    return q[63:0];
  endfunction

endpackage

// File: rtl/dw_quant.sv
// Combinational round, saturate and optional ReLU of a wide accumulator.
module dw_quant
  import dw_pkg::*;
#(
  parameter int DW   = 32,
  parameter int ACCW = 2 * DW + 8,
  parameter int FRAC = 8
) (
  input  logic signed [ACCW-1:0] acc,
  input  logic                   relu_en,
  output logic signed [DW-1:0]   q
);

  logic signed [SAT_W-1:0] acc_ext;
  logic signed [63:0]      sat;

  always_comb begin
    acc_ext = {{(SAT_W - ACCW){acc[ACCW-1]}}, acc};
    sat     = sat_round(acc_ext, FRAC, DW);
    if (relu_en && sat[63]) q = '0;
    else q = sat[DW-1:0];
  end

endmodule

// File: rtl/dw_conv_pe.sv
// Depthwise convolution PE: one weight popped per accepted pixel, KSIZE^2-tap MAC,
// bias, quantisation and a single-entry output register.
module dw_conv_pe
  import dw_pkg::*;
#(
  parameter int DW    = 32,
  parameter int KSIZE = KSIZE_DEF,
  parameter int FRAC  = 8,
  parameter int ACCW  = acc_width(DW)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 weight_load,
  input  logic                 w_valid,
  output logic                 dw_ready,
  input  logic signed [DW-1:0] dw_out,
  input  logic signed [DW-1:0] bias,
  input  logic                 relu_en,
  input  logic                 pix_valid,
  output logic                 pix_ready,
  input  logic signed [DW-1:0] pix_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW-1:0]        out_data
);

  localparam int NTAPS = KSIZE * KSIZE;
  localparam int TW    = (NTAPS > 1) ? $clog2(NTAPS) : 1;

  logic [TW-1:0]           tap_reg;
  logic                    fire, tap_first, tap_last, s1_done;
  logic                    s1_valid_reg, s1_first_reg, s1_last_reg, s1_relu_reg;
  logic signed [DW-1:0]    s1_bias_reg;
  logic [2*DW-1:0]         s1_prod_reg;
  logic signed [ACCW-1:0]  acc_reg, acc_next;
  logic signed [DW-1:0]    q_next;
  logic                    out_valid_reg;
  logic [DW-1:0]           out_data_reg;

  // The last tap sitting in S1 blocks new pixels so only one window is in flight.
  assign s1_done   = s1_valid_reg & s1_last_reg;
  assign pix_ready = ~rst & ~weight_load & ~s1_done & (~out_valid_reg | out_ready);
  assign fire      = pix_valid & pix_ready & w_valid;
  assign dw_ready  = fire;
  assign tap_first = (tap_reg == '0);
  assign tap_last  = (tap_reg == TW'(NTAPS - 1));
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;

  always_comb begin
    acc_next = (s1_first_reg ? {{(ACCW - DW){s1_bias_reg[DW-1]}}, s1_bias_reg} : acc_reg)
             + {{(ACCW - 2 * DW){s1_prod_reg[2*DW-1]}}, s1_prod_reg};
  end

  dw_quant #(
    .DW  (DW),
    .ACCW(ACCW),
    .FRAC(FRAC)
  ) u_quant (
    .acc    (acc_next),
    .relu_en(s1_relu_reg),
    .q      (q_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      tap_reg       <= '0;
      s1_valid_reg  <= 1'b0;
      s1_first_reg  <= 1'b0;
      s1_last_reg   <= 1'b0;
      s1_relu_reg   <= 1'b0;
      s1_bias_reg   <= '0;
      s1_prod_reg   <= '0;
      acc_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else if (weight_load) begin
      // Abort the partial window but still deliver a result already held.
      tap_reg      <= '0;
      s1_valid_reg <= 1'b0;
      acc_reg      <= '0;
      if (out_valid_reg && out_ready) out_valid_reg <= 1'b0;
    end else begin
      s1_valid_reg <= fire;
      if (fire) begin
        tap_reg      <= tap_last ? '0 : tap_reg + TW'(1);
        // Sign-extended operands make the unsigned product bit-exact for signed inputs.
        s1_prod_reg  <= {{DW{pix_data[DW-1]}}, pix_data} * {{DW{dw_out[DW-1]}}, dw_out};
        s1_first_reg <= tap_first;
        s1_last_reg  <= tap_last;
        if (tap_first) s1_bias_reg <= bias;
        if (tap_last) s1_relu_reg <= relu_en;
      end
      if (s1_valid_reg) acc_reg <= acc_next;
      if (s1_done) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= q_next;
      end else if (out_valid_reg && out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dw_conv_pe.sv
// Scoreboard bench for dw_conv_pe: three configurations (FRAC 0/8, DW 16) share stimulus.
module tb_dw_conv_pe;

  logic clk = 1'b0;
  logic rst, weight_load, w_valid, relu_en, pix_valid, out_ready;
  logic signed [31:0] dw_out, bias, pix_data;
  logic dw_ready0, dw_ready8, dw_ready16;
  logic pix_ready0, pix_ready8, pix_ready16;
  logic ov0, ov8, ov16;
  logic [31:0] od0, od8;
  logic [15:0] od16;
  logic fire_tb;

  int tests = 0;
  int fails = 0;
  int dw_cnt = 0;

  typedef struct {
    logic [63:0] e0;
    logic [63:0] e8;
    logic [63:0] e16;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  assign fire_tb = pix_valid & pix_ready0 & w_valid;

  dw_conv_pe #(.DW(32), .FRAC(0)) u0 (
    .clk(clk), .rst(rst), .weight_load(weight_load), .w_valid(w_valid),
    .dw_ready(dw_ready0), .dw_out(dw_out), .bias(bias), .relu_en(relu_en),
    .pix_valid(pix_valid), .pix_ready(pix_ready0), .pix_data(pix_data),
    .out_valid(ov0), .out_ready(out_ready), .out_data(od0));

  dw_conv_pe #(.DW(32), .FRAC(8)) u8 (
    .clk(clk), .rst(rst), .weight_load(weight_load), .w_valid(w_valid),
    .dw_ready(dw_ready8), .dw_out(dw_out), .bias(bias), .relu_en(relu_en),
    .pix_valid(pix_valid), .pix_ready(pix_ready8), .pix_data(pix_data),
    .out_valid(ov8), .out_ready(out_ready), .out_data(od8));

  dw_conv_pe #(.DW(16), .FRAC(0)) u16 (
    .clk(clk), .rst(rst), .weight_load(weight_load), .w_valid(w_valid),
    .dw_ready(dw_ready16), .dw_out(dw_out[15:0]), .bias(bias[15:0]), .relu_en(relu_en),
    .pix_valid(pix_valid), .pix_ready(pix_ready16), .pix_data(pix_data[15:0]),
    .out_valid(ov16), .out_ready(out_ready), .out_data(od16));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic signed [127:0] sx32(input logic signed [31:0] v);
    return v;
  endfunction

  function automatic logic signed [127:0] sx16(input logic signed [15:0] v);
    return v;
  endfunction

  // Reference quantiser: round half up, clamp, ReLU, masked to dw bits.
  function automatic logic [63:0] ref_q(input logic signed [127:0] a, input int frac,
                                        input int dw, input bit relu);
    logic signed [127:0] one, v, mx, mn;
    one = 1;
    v = a;
    if (frac > 0) v = (a + (one <<< (frac - 1))) >>> frac;
    mx = (one <<< (dw - 1)) - one;
    mn = -mx - one;
    if (v > mx) v = mx;
    if (v < mn) v = mn;
    if (relu && v < 0) v = 0;
    return v[63:0] & ((64'd1 << dw) - 64'd1);
  endfunction

  function automatic logic signed [31:0] rv();
    logic signed [31:0] v;
    v = $urandom;
    return v >>> $urandom_range(0, 24);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_tap(input logic signed [31:0] p, input logic signed [31:0] w, input bit rnd);
    bit got;
    got = 1'b0;
    pix_data = p;
    dw_out = w;
    for (int n = 0; n < 300 && !got; n++) begin
      pix_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      w_valid   = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (rnd) out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      got = fire_tb;
      step();
    end
    pix_valid = 1'b0;
    chk("tap_accepted", 64'(got), 64'd1);
  endtask

  // Returns at a negedge where out_valid is high (or after the budget expires).
  task automatic wait_out(input string tag);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk);
      seen = ov0;
      if (!seen) step();
    end
    chk(tag, 64'(seen), 64'd1);
  endtask

  // Monitor: reference model on fires, scoreboard pop on output handshakes.
  initial begin
    logic signed [127:0] a32, a16;
    int mt;
    exp_t e;
    mt = 0;
    a32 = 0;
    a16 = 0;
    forever begin
      @(negedge clk);
      if (rst || weight_load) begin
        mt = 0;
      end else begin
        chk("dw_ready_eq_fire", 64'(dw_ready0), 64'(fire_tb));
        if (dw_ready0) dw_cnt++;
        if (fire_tb) begin
          if (mt == 0) begin
            a32 = sx32(bias);
            a16 = sx16(bias[15:0]);
          end
          a32 = a32 + sx32(pix_data) * sx32(dw_out);
          a16 = a16 + sx16(pix_data[15:0]) * sx16(dw_out[15:0]);
          if (mt == 8) begin
            e.e0  = ref_q(a32, 0, 32, relu_en);
            e.e8  = ref_q(a32, 8, 32, relu_en);
            e.e16 = ref_q(a16, 0, 16, relu_en);
            sb.push_back(e);
            mt = 0;
          end else begin
            mt++;
          end
        end
        if (ov0 && out_ready) begin
          chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("out_frac0", 64'(od0), e.e0);
            chk("out_frac8", 64'(od8), e.e8);
            chk("out_dw16", 64'(od16), e.e16);
          end
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    rst = 1'b1; weight_load = 1'b0; w_valid = 1'b1; relu_en = 1'b0;
    pix_valid = 1'b1; out_ready = 1'b1; dw_out = 0; bias = 0; pix_data = 0;
    repeat (3) step();
    @(negedge clk);
    chk("rst_out_valid", 64'(ov0), 64'd0);
    chk("rst_out_data", 64'(od0), 64'd0);
    chk("rst_pix_ready", 64'(pix_ready0), 64'd0);
    chk("rst_dw_ready", 64'(dw_ready0), 64'd0);
    step();
    rst = 1'b0;
    pix_valid = 1'b0;

    // Pixels 1..9 with unit weights, bias 0.
    c0 = dw_cnt;
    for (int i = 1; i <= 9; i++) send_tap(i, 1, 1'b0);
    @(negedge clk);
    chk("t1_latency_n1", 64'(ov0), 64'd0);
    @(negedge clk);
    chk("t1_latency_n2", 64'(ov0), 64'd1);
    chk("t1_sum", 64'(od0), 64'd45);
    chk("t1_dw_pops", 64'(dw_cnt - c0), 64'd9);
    step();

    // Fixed-point -1.0 * 1.0 taps, with and without ReLU.
    relu_en = 1'b1;
    for (int i = 0; i < 9; i++) send_tap(-256, 256, 1'b0);
    wait_out("t2a_valid");
    chk("t2a_relu", 64'(od8), 64'd0);
    step();
    relu_en = 1'b0;
    for (int i = 0; i < 9; i++) send_tap(-256, 256, 1'b0);
    wait_out("t2b_valid");
    chk("t2b_neg", 64'(od8), 64'hFFFF_F700);
    step();

    // Saturation in both directions.
    for (int i = 0; i < 9; i++) send_tap(32767, 32767, 1'b0);
    wait_out("t3a_valid");
    chk("t3a_sat16_pos", 64'(od16), 64'h7FFF);
    chk("t3a_sat32_pos", 64'(od0), 64'h7FFF_FFFF);
    step();
    for (int i = 0; i < 9; i++) send_tap(-32767, 32767, 1'b0);
    wait_out("t3b_valid");
    chk("t3b_sat16_neg", 64'(od16), 64'h8000);
    chk("t3b_sat32_neg", 64'(od0), 64'h8000_0000);
    step();

    // Backpressure: result held for 20 cycles, no pixels or weights taken.
    out_ready = 1'b0;
    bias = 1;
    for (int i = 1; i <= 9; i++) send_tap(i, 3, 1'b0);
    wait_out("t4_valid");
    step();
    bias = 0;
    pix_data = 7; dw_out = 1; pix_valid = 1'b1; w_valid = 1'b1;
    c0 = dw_cnt;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      chk("hold_valid", 64'(ov0), 64'd1);
      chk("hold_data", 64'(od0), sb[0].e0);
      chk("hold_pix_ready", 64'(pix_ready0), 64'd0);
      step();
    end
    chk("hold_no_pop", 64'(dw_cnt - c0), 64'd0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_pix_ready", 64'(pix_ready0), 64'd1);
    chk("release_fire", 64'(dw_ready0), 64'd1);
    step();
    pix_valid = 1'b0;
    for (int i = 0; i < 8; i++) send_tap(7, 1, 1'b0);
    wait_out("t4b_valid");
    chk("t4b_sum", 64'(od0), 64'd63);
    step();

    // Kernel reload after tap 4 aborts the window.
    bias = 9;
    for (int i = 0; i < 5; i++) send_tap(100, 3, 1'b0);
    weight_load = 1'b1;
    pix_valid = 1'b1;
    @(negedge clk);
    chk("wl_pix_ready", 64'(pix_ready0), 64'd0);
    step();
    weight_load = 1'b0;
    pix_valid = 1'b0;
    bias = 5;
    for (int i = 0; i < 9; i++) send_tap(1, 2, 1'b0);
    wait_out("wl_valid");
    chk("wl_sum", 64'(od0), 64'd23);
    step();
    repeat (5) step();
    chk("wl_single_result", 64'(sb.size()), 64'd0);

    // Reset while a result is held discards it.
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) send_tap(2, 2, 1'b0);
    wait_out("rst_hold_valid");
    step();
    rst = 1'b1;
    sb.delete();
    step();
    @(negedge clk);
    chk("rst_drop_valid", 64'(ov0), 64'd0);
    chk("rst_drop_data", 64'(od0), 64'd0);
    step();
    rst = 1'b0;
    out_ready = 1'b1;

    // Random gaps on pix_valid, w_valid and out_ready over 100 windows.
    c0 = dw_cnt;
    for (int w = 0; w < 100; w++) begin
      bias = rv();
      relu_en = $urandom_range(0, 1);
      for (int t = 0; t < 9; t++) send_tap(rv(), rv(), 1'b1);
    end
    out_ready = 1'b1;
    w_valid = 1'b1;
    for (int n = 0; n < 100 && sb.size() != 0; n++) step();
    step();
    chk("rand_drained", 64'(sb.size()), 64'd0);
    chk("rand_dw_pops", 64'(dw_cnt - c0), 64'd900);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
